// File: rtl/edge_event_arb.sv
// edge_event_arb: N-line rising-edge detector feeding a round-robin event queue.
// Each detected edge sets a pending bit, and one event at a time is handed to a
// single consumer over a valid/ready handshake. A second edge on a line whose
// event is still pending is merged and raises that line's sticky overflow flag.
// Optional macro EDGE_ARB_SYNC_EN puts a 2-flop synchronizer on every input line.
//
// state | meaning
// IDLE  | nothing offered, o_vld=0; waits for any pending line
// OFFER | o_vld=1, o_id held until the consumer raises o_rdy
module edge_event_arb #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic           c,
   input  logic           r_n,
   input  logic [N-1:0]   i,
   output logic           o_vld,
   input  logic           o_rdy,
   output logic [IDW-1:0] o_id,
   output logic [N-1:0]   o_ovf,
   input  logic           clr_ovf
);

   typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   in_w, i_t_q, edge_w;
   logic [N-1:0]   pending_q, pending_d, take_w;
   logic [N-1:0]   ovf_q, ovf_d;
   logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d;
   logic [IDW-1:0] ptr_next, scan_base, sel_off, sel_idx;
   logic [IDW:0]   sel_sum;
   logic [2*N-1:0] dbl_w;
   logic [N-1:0]   rot_w;
   logic           sel_found, take, armed_q;

`ifdef EDGE_ARB_SYNC_EN
   logic [N-1:0] sync1_q, sync2_q;

   // two-flop synchronizer on every raw line
   always_ff @(posedge c or negedge r_n) begin
      if (!r_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= i;
         sync2_q <= sync1_q;
      end
   end
   assign in_w = sync2_q;
`else
   assign in_w = i;
`endif

   // previous-level register; the first clock after reset only samples levels,
   // so a line that is already high when reset releases never makes an event
   always_ff @(posedge c or negedge r_n) begin
      if (!r_n) begin
         i_t_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         i_t_q   <= in_w;
         armed_q <= 1'b1;
      end
   end

   assign edge_w = in_w & ~i_t_q & {N{armed_q}};

   // pointer after a transfer wraps explicitly so non-power-of-2 N stays < N
   assign ptr_next  = (id_q == IDW'(N-1)) ? '0 : id_q + IDW'(1);
   assign scan_base = (state_q == OFFER) ? ptr_next : ptr_q;

   // round-robin pick: rotate pending so scan_base lands on bit 0, take lowest set bit
   always_comb begin
      dbl_w     = {pending_q, pending_q} >> scan_base;
      rot_w     = dbl_w[N-1:0];
      sel_found = 1'b0;
      sel_off   = '0;
      for (int k = N-1; k >= 0; k--) begin
         if (rot_w[k]) begin
            sel_found = 1'b1;
            sel_off   = IDW'(k);
         end
      end
      sel_sum = {1'b0, scan_base} + {1'b0, sel_off};
      if (sel_sum >= (IDW+1)'(N)) sel_sum = sel_sum - (IDW+1)'(N);
      sel_idx = sel_sum[IDW-1:0];
   end

   // handshake FSM: load a new event from IDLE or straight after a transfer
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      take    = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               take    = 1'b1;
               id_d    = sel_idx;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (o_rdy) begin
               ptr_d = ptr_next;
               if (sel_found) begin
                  take = 1'b1;
                  id_d = sel_idx;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // pending and overflow next-state; an edge on the taken line re-arms it
   always_comb begin
      for (int k = 0; k < N; k++) begin
         take_w[k] = take && (sel_idx == IDW'(k));
      end
      pending_d = edge_w | (pending_q & ~take_w);
      ovf_d     = (ovf_q & ~{N{clr_ovf}}) | (edge_w & pending_q & ~take_w);
   end

   // state registers
   always_ff @(posedge c or negedge r_n) begin
      if (!r_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         id_q      <= '0;
         pending_q <= '0;
         ovf_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         id_q      <= id_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
      end
   end

   assign o_vld = (state_q == OFFER);
   assign o_id  = id_q;
   assign o_ovf = ovf_q;

endmodule

// File: tb/tb_edge_event_arb.sv
// Directed bench for edge_event_arb (default build, no input synchronizer).
module tb_edge_event_arb;
   localparam int N = 4;

   logic         c       = 1'b0;
   logic         r_n     = 1'b0;
   logic         o_rdy   = 1'b0;
   logic         clr_ovf = 1'b0;
   logic [N-1:0] i       = '0;
   logic         o_vld;
   logic [1:0]   o_id;
   logic [N-1:0] o_ovf;

   int n_checks = 0;
   int n_pass   = 0;

   edge_event_arb #(.N(N)) dut (
      .c       (c),
      .r_n     (r_n),
      .i       (i),
      .o_vld   (o_vld),
      .o_rdy   (o_rdy),
      .o_id    (o_id),
      .o_ovf   (o_ovf),
      .clr_ovf (clr_ovf)
   );

   always #5 c = ~c;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge c);
      #1;
   endtask

   // reset, check reset outputs, release, then consume the level-priming edge
   task automatic do_reset();
      r_n     = 1'b0;
      i       = '0;
      o_rdy   = 1'b0;
      clr_ovf = 1'b0;
      @(negedge c);
      @(negedge c);
      check("rst_vld", o_vld, 0);
      check("rst_id", o_id, 0);
      check("rst_ovf", o_ovf, 0);
      r_n = 1'b1;
      tick();
   endtask

   initial begin
      // single event on line 2, latency and pointer update
      do_reset();
      i = 4'b0100;
      tick();
      check("t1_vld_p1", o_vld, 0);
      tick();
      check("t1_vld_p2", o_vld, 1);
      check("t1_id_p2", o_id, 2);
      o_rdy = 1'b1;
      tick();
      check("t1_vld_done", o_vld, 0);
      check("t1_ptr", dut.ptr_q, 3);
      o_rdy = 1'b0;

      // all four lines at once, back-to-back transfers
      do_reset();
      i     = 4'b1111;
      o_rdy = 1'b1;
      tick();
      check("t2_vld_p1", o_vld, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t2_vld", o_vld, 1);
         check("t2_id", o_id, k);
      end
      tick();
      check("t2_vld_end", o_vld, 0);
      check("t2_ovf", o_ovf, 0);
      o_rdy = 1'b0;

      // two edges on line 1 while line 0 is stalled -> overflow, one event
      do_reset();
      i = 4'b0001;
      tick();
      tick();
      check("t3_vld_p2", o_vld, 1);
      check("t3_id_p2", o_id, 0);
      i = 4'b0011;
      tick();
      check("t3_ovf_p3", o_ovf, 0);
      i = 4'b0001;
      tick();
      i = 4'b0011;
      tick();
      check("t3_ovf_p5", o_ovf, 4'b0010);
      check("t3_vld_p5", o_vld, 1);
      check("t3_id_p5", o_id, 0);
      o_rdy = 1'b1;
      tick();
      check("t3_vld_p6", o_vld, 1);
      check("t3_id_p6", o_id, 1);
      tick();
      check("t3_vld_p7", o_vld, 0);
      o_rdy = 1'b0;
      tick();
      tick();
      check("t3_vld_quiet", o_vld, 0);
      check("t3_ovf_sticky", o_ovf, 4'b0010);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("t3_ovf_clr", o_ovf, 0);

      // id 3 stalled for 5 cycles, line 0 rises meanwhile, pointer wraps to 0
      do_reset();
      i = 4'b1000;
      tick();
      tick();
      check("t4_vld", o_vld, 1);
      check("t4_id", o_id, 3);
      i = 4'b1001;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t4_id_hold", o_id, 3);
         check("t4_vld_hold", o_vld, 1);
      end
      o_rdy = 1'b1;
      tick();
      check("t4_vld_wrap", o_vld, 1);
      check("t4_id_wrap", o_id, 0);
      tick();
      check("t4_vld_end", o_vld, 0);
      o_rdy = 1'b0;

      // line 2 re-edges on the cycle its pending bit is taken
      do_reset();
      i = 4'b0101;
      tick();
      tick();
      check("t5_id_p2", o_id, 0);
      i = 4'b0001;
      tick();
      i     = 4'b0101;
      o_rdy = 1'b1;
      tick();
      check("t5_vld_p4", o_vld, 1);
      check("t5_id_p4", o_id, 2);
      check("t5_ovf_p4", o_ovf, 0);
      tick();
      check("t5_vld_p5", o_vld, 1);
      check("t5_id_p5", o_id, 2);
      tick();
      check("t5_vld_p6", o_vld, 0);
      check("t5_ovf_p6", o_ovf, 0);
      o_rdy = 1'b0;

      // asynchronous reset during OFFER with lines 1,2 still pending
      do_reset();
      i = 4'b0111;
      tick();
      tick();
      check("t6_vld_pre", o_vld, 1);
      check("t6_id_pre", o_id, 0);
      #2;
      r_n = 1'b0;
      #1;
      check("t6_vld_async", o_vld, 0);
      check("t6_id_async", o_id, 0);
      check("t6_ovf_async", o_ovf, 0);
      @(negedge c);
      r_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t6_vld_after", o_vld, 0);
      end
      check("t6_pending", dut.pending_q, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/edge_event_arb.md
Name: edge_event_arb

Overview:
- Rising-edge scheduler. Runs N independent rising-edge detectors and queues each detected edge as a pending event.
- Events are handed one at a time to a single shared downstream consumer over a valid/ready handshake.
- Arbitration between lines is round-robin.
- Sits between raw pulse/level sources (buttons, strobes, status lines) and one event-handling engine.

Parameters:
N, 4, number of input lines (legal range 2..16)
IDW, $clog2(N), width of event id (derived; do not override)

Ports:
c  input  1  clock; all state updates on posedge c
r_n  input  1  reset; asynchronous assert, active-low
i  input  N  raw input lines, bit k = line k
o_vld  output  1  event offered to consumer
o_rdy  input  1  consumer accepts offered event
o_id  output  IDW  line index of offered event
o_ovf  output  N  sticky overflow flag per line
clr_ovf  input  1  synchronous clear of all o_ovf bits

Behaviour:
- Reset (r_n low, takes effect immediately):
  - i_t, pending, o_ovf all cleared to 0.
  - o_vld=0, o_id=0.
  - RR pointer ptr=0.
  - FSM=IDLE.
  - Line already high when reset releases: no event (i_t samples it on the first clock after release, so the level counts as already seen).
- Edge detect, per line k:
  - i_t[k] <= in[k] every cycle.
  - edge[k] = in[k] & ~i_t[k], combinational.
  - in = i directly, or the synchronized i (see Optional Feature).
- Pending, per line k, at each posedge:
  - edge[k]=1: pending[k] <= 1.
  - Line k taken by the arbiter this cycle and no edge: pending[k] <= 0.
  - Edge on the same cycle its pending bit is taken: pending[k] stays 1. This is a new event, not an overflow.
- Overflow:
  - edge[k] while pending[k]=1 and pending[k] not taken this cycle: o_ovf[k] <= 1. The event is lost (merged).
  - clr_ovf=1: all o_ovf <= 0.
  - clr_ovf and a new overflow on the same cycle: set wins for that bit.
- Selection: first set pending bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- FSM:
  - IDLE, o_vld=0. If any pending: take the selected line k, pending[k] cleared, o_id<=k, o_vld<=1, go to OFFER.
  - OFFER, o_vld=1, o_id held stable while o_rdy=0.
  - OFFER with o_rdy=1 (transfer): ptr <= (o_id+1) mod N.
    - If any pending (excluding the line just transferred unless it re-edged), select again using the new ptr, load o_id, keep o_vld=1. Back-to-back transfers give 1 event/cycle.
    - Otherwise o_vld<=0, go to IDLE.
- o_rdy is ignored while o_vld=0.
- o_id is only meaningful while o_vld=1. In IDLE it holds its last value.
- Latency (no sync): i rises between posedge k-1 and posedge k → pending set at posedge k → o_vld=1 after posedge k+1.
- Reset mid-OFFER: the event is dropped. o_vld falls asynchronously; no transfer is counted.
- N not a power of 2: ptr wraps from N-1 to 0. o_id never takes values ≥ N.

Optional Feature:
- Macro: EDGE_ARB_SYNC_EN.
- Defined:
  - Each i bit passes through a 2-flop synchronizer (reset to 0) before edge detection: in = sync2(i).
  - Adds 2 cycles of latency (i to o_vld = 4 posedges).
- Not defined: in = i, no synchronizer flops. i must be synchronous to c.

Test Plan:
- Reset release with i=4'b0000, then i[2] 0→1 before posedge 1 → pending[2] set at posedge 1; o_vld=1, o_id=2 after posedge 2; o_rdy=1 → o_vld=0 next cycle, ptr=3.
- i=4'b1111 rises together, o_rdy held 1 → o_id sequence 0,1,2,3 on 4 consecutive cycles with o_vld continuously 1, then o_vld=0; o_ovf=0.
- i[1] pulses 0→1→0→1 (2 edges, 2 cycles apart) while o_rdy=0 and line 0 is being offered → o_ovf[1]=1; only one line-1 event delivered; clr_ovf pulse → o_ovf=0.
- o_rdy=0 for 5 cycles during OFFER of id 3 while i[0] rises → o_id stays 3 throughout; after accept, o_id=0 next cycle (wrap from ptr=0).
- Line 2 re-edges on the same cycle its pending bit is taken → a second id-2 event is delivered later; o_ovf[2]=0.
- r_n low during OFFER with pending=4'b0110 → o_vld=0 immediately; after release no events offered; i held high produces no event.
